// File: rtl/cordic_rot_iter.sv
`timescale 1ns/1ps
// cordic_rot_iter: iterative CORDIC rotation-mode engine.
// Rotates (x, y) by a 16-bit binary angle (32768 = pi), one micro-rotation
// per clock, with one transaction in flight at a time.
//
// Optional build macro CORDIC_GAIN_COMP_EN adds a GAIN state that scales the
// result by K = 0.60725 (Q1.15), giving roughly unity gain.
//
// Ports:
//   clk        clock, posedge
//   clr        asynchronous active-high reset
//   in_valid   input transaction present
//   in_ready   engine idle and able to accept
//   x_in/y_in  signed W-bit input vector
//   ang_in     signed 16-bit binary angle
//   out_valid  result held on x_out/y_out
//   out_ready  consumer accepts result
//   x_out/y_out signed W+2-bit rotated vector
module cordic_rot_iter #(
  parameter int unsigned W    = 16,
  parameter int unsigned ITER = 14
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [15:0]  ang_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+1:0] x_out,
  output logic signed [W+1:0] y_out
);

  localparam int unsigned XW = W + 2;
  localparam int unsigned ZW = 16;
  localparam int unsigned IW = 4;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned PW = XW + 16;
  localparam logic signed [15:0] GAIN_K = 16'sd19898;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_GAIN,
    S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_DONE
  } state_t;
`endif

  state_t state, state_nxt;

  logic signed [XW-1:0] x, y, x_nxt, y_nxt, xs, ys;
  logic signed [ZW-1:0] z, z_nxt, atan;
  logic [IW-1:0]        i, i_nxt;
  logic                 load_out;

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [PW-1:0] px, py;
`endif

  // arctan(2^-k) in binary-angle units
  function automatic logic signed [ZW-1:0] atan_lut(input logic [IW-1:0] k);
    case (k)
      4'd0:    atan_lut = 16'sd8192;
      4'd1:    atan_lut = 16'sd4836;
      4'd2:    atan_lut = 16'sd2555;
      4'd3:    atan_lut = 16'sd1297;
      4'd4:    atan_lut = 16'sd651;
      4'd5:    atan_lut = 16'sd326;
      4'd6:    atan_lut = 16'sd163;
      4'd7:    atan_lut = 16'sd81;
      4'd8:    atan_lut = 16'sd41;
      4'd9:    atan_lut = 16'sd20;
      4'd10:   atan_lut = 16'sd10;
      4'd11:   atan_lut = 16'sd5;
      4'd12:   atan_lut = 16'sd3;
      4'd13:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    z_nxt     = z;
    i_nxt     = i;
    load_out  = 1'b0;
    xs        = x >>> i;
    ys        = y >>> i;
    atan      = atan_lut(i);
`ifdef CORDIC_GAIN_COMP_EN
    px        = PW'(x) * PW'(GAIN_K);
    py        = PW'(y) * PW'(GAIN_K);
`endif

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          x_nxt     = XW'(x_in);
          y_nxt     = XW'(y_in);
          z_nxt     = ang_in;
          state_nxt = S_PRE;
        end
      end

      // Fold angles outside [-pi/2, pi/2) by rotating pi up front
      S_PRE: begin
        if (z[15] != z[14]) begin
          x_nxt = -x;
          y_nxt = -y;
          z_nxt = {~z[15], z[14:0]};
        end
        i_nxt     = '0;
        state_nxt = S_ITER;
      end

      S_ITER: begin
        if (!z[15]) begin
          x_nxt = x - ys;
          y_nxt = y + xs;
          z_nxt = z - atan;
        end else begin
          x_nxt = x + ys;
          y_nxt = y - xs;
          z_nxt = z + atan;
        end
        i_nxt = i + IW'(1);
        if (i == IW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = S_GAIN;
`else
          state_nxt = S_DONE;
          load_out  = 1'b1;
`endif
        end
      end

`ifdef CORDIC_GAIN_COMP_EN
      // Scale by K in Q1.15; arithmetic shift floors toward -inf
      S_GAIN: begin
        x_nxt     = XW'(px >>> 15);
        y_nxt     = XW'(py >>> 15);
        state_nxt = S_DONE;
        load_out  = 1'b1;
      end
`endif

      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      x         <= x_nxt;
      y         <= y_nxt;
      z         <= z_nxt;
      i         <= i_nxt;
      if (load_out) begin
        x_out <= x_nxt;
        y_out <= y_nxt;
      end
      out_valid <= (state_nxt == S_DONE);
      in_ready  <= (state_nxt == S_IDLE);
    end
  end

endmodule
